bias_reg_bank_pp: RTL and testbench
===================================

BIAS_REG_BANK_PP -- requirements
Module: bias_reg_bank_pp

Interface
REQ-001 SHALL have parameter FW, default 16, meaning bias word width in bits.
REQ-002 SHALL have parameter DW, default 512, meaning input package width in bits.
REQ-003 SHALL have parameter RL, default 512, meaning bias words per bank.
REQ-004 SHALL derive PACKAGE_LEN = DW/FW, PACKAGE_NUM = RL/PACKAGE_LEN, AW = clog2(PACKAGE_NUM); legal configurations: DW%FW==0, RL%PACKAGE_LEN==0, PACKAGE_NUM>=2.
REQ-005 SHALL have clk_i  input  1  the only clock; all state updates on its posedge.
REQ-006 SHALL have rst_i  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have start_i  input  1  pulse that begins a load into the shadow bank.
REQ-008 SHALL have len_i  input  AW+1  number of packages to load, sampled with start_i.
REQ-009 SHALL have valid_i  input  1  data_i carries a valid package.
REQ-010 SHALL have data_i  input  DW  bias package, PACKAGE_LEN words.
REQ-011 SHALL have swap_i  input  1  pulse that makes the loaded shadow bank active.
REQ-012 SHALL have ready_o  output  1  block accepts packages (state LOAD).
REQ-013 SHALL have loaded_o  output  1  shadow bank complete, awaiting swap (state FULL).
REQ-014 SHALL have bank_sel_o  output  1  index of the active bank.
REQ-015 SHALL have bias_o  output  RL*FW  active bank contents; package k at bits [(k+1)*DW-1 : k*DW].

Function
REQ-016 SHALL hold two banks of PACKAGE_NUM x DW registers: active (drives bias_o) and shadow (load target).
REQ-017 SHALL implement FSM states IDLE, LOAD, FULL; ready_o = (state==LOAD), loaded_o = (state==FULL), both registered-state decodes.
REQ-018 IDLE: start_i with 1 <= len_i <= PACKAGE_NUM -> LOAD next cycle, latch len_i, write counter := 0, shadow bank cleared to zero in the same edge.
REQ-019 IDLE: start_i with len_i==0 or len_i>PACKAGE_NUM SHALL be ignored (stay IDLE, no bank change).
REQ-020 LOAD: each cycle with valid_i=1 SHALL write data_i to shadow[counter] and increment counter; valid_i=0 cycles stall with no change.
REQ-021 LOAD: the beat written when counter == len-1 SHALL move state to FULL on that edge; loaded_o is high the next cycle.
REQ-022 Shadow packages at index >= len SHALL read as zero after swap.
REQ-023 FULL: swap_i SHALL toggle bank_sel_o; bias_o reflects the newly active bank from the cycle after swap_i is sampled; state -> IDLE.
REQ-024 FULL: swap_i and start_i in the same cycle SHALL swap and, if len_i legal, enter LOAD targeting the new shadow (previously active) bank, clearing it; illegal len_i -> IDLE.
REQ-025 start_i in LOAD or FULL (without swap_i), and swap_i in IDLE or LOAD, SHALL be ignored.
REQ-026 Active bank contents and bias_o SHALL never change during LOAD or FULL; they change only on swap or reset.
REQ-027 Counter SHALL never exceed len-1; valid_i outside LOAD SHALL be ignored.

Reset
REQ-028 On rst_i=1 (any state, asynchronously) both banks SHALL be zero, state IDLE, counter 0, bank_sel_o=0, ready_o=0, loaded_o=0, bias_o=0.
REQ-029 Reset asserted mid-LOAD SHALL discard the partial load; after release the block SHALL accept start_i on the first posedge.

Verification (defaults: PACKAGE_LEN=32, PACKAGE_NUM=16)
REQ-030 Assert rst_i -> bias_o=0, ready_o=0, loaded_o=0, bank_sel_o=0 without a clock edge.
REQ-031 start_i, len_i=16; 16 beats, package k = word (k+1) replicated, valid_i gaps every 3rd cycle -> loaded_o=1 the cycle after beat 16, bias_o still 0; swap_i -> next cycle bank_sel_o=1, package k of bias_o = word k+1.
REQ-032 After REQ-031, load len_i=3 with packages 0xAAAA.. and swap -> packages 0..2 = 0xAAAA.., packages 3..15 = 0, bank_sel_o=0.
REQ-033 In FULL assert swap_i and start_i (len_i=16) together -> bank_sel_o toggles, ready_o=1 next cycle, bias_o unchanged for all 16 load beats.
REQ-034 swap_i in IDLE, start_i in LOAD, start_i with len_i=0 and len_i=17 -> no change to state, counter, bank_sel_o or bias_o.
REQ-035 rst_i asserted after 5 of 16 beats -> all outputs zero, IDLE; new load of len_i=2 and swap -> only packages 0..1 nonzero.

Source files
------------

// File: rtl/bias_reg_bank_pp.sv
// -----------------------------------------------------------------------------
// bias_reg_bank_pp
//
// Double-buffered (ping-pong) bias register bank. One bank is "active" and
// drives bias_o continuously; the other is the "shadow" bank that gets filled
// package by package. A swap pulse makes the freshly loaded shadow bank the
// active one, so downstream logic never sees a partially written bias set.
//
// Ports
//   clk_i      : clock, all state updates on posedge
//   rst_i      : asynchronous active-high reset (clears both banks)
//   start_i    : pulse, begins a load of len_i packages into the shadow bank
//   len_i      : number of packages to load (1..PACKAGE_NUM), sampled with start_i
//   valid_i    : data_i holds a valid package this cycle
//   data_i     : one package of PACKAGE_LEN bias words
//   swap_i     : pulse, makes the completely loaded shadow bank active
//   ready_o    : block is accepting packages (LOAD)
//   loaded_o   : shadow bank complete, waiting for swap (FULL)
//   bank_sel_o : index of the active bank
//   bias_o     : active bank contents, package k at bits [(k+1)*DW-1 : k*DW]
// -----------------------------------------------------------------------------
module bias_reg_bank_pp #(
  parameter  int FW          = 16,
  parameter  int DW          = 512,
  parameter  int RL          = 512,
  localparam int PACKAGE_LEN = DW / FW,
  localparam int PACKAGE_NUM = RL / PACKAGE_LEN,
  localparam int AW          = $clog2(PACKAGE_NUM)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [AW:0]        len_i,
  input  logic               valid_i,
  input  logic [DW-1:0]      data_i,
  input  logic               swap_i,
  output logic               ready_o,
  output logic               loaded_o,
  output logic               bank_sel_o,
  output logic [RL*FW-1:0]   bias_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_FULL
  } state_t;

  localparam logic [AW:0] PN_MAX = (AW+1)'(PACKAGE_NUM);

  state_t                       r_state;
  state_t                       w_next;
  logic [PACKAGE_NUM*DW-1:0]    r_bank [2];
  logic                         r_bank_sel;
  logic [AW-1:0]                r_cnt;
  logic [AW:0]                  r_len;

  logic                         w_len_ok;
  logic                         w_swap;
  logic                         w_start;
  logic                         w_beat;
  logic                         w_last;
  logic                         w_clear_bank;

  assign w_len_ok = (len_i != '0) && (len_i <= PN_MAX);
  assign w_swap   = (r_state == S_FULL) && swap_i;
  // A start is honoured from IDLE, or from FULL only when it rides along with a swap.
  assign w_start  = start_i && w_len_ok && ((r_state == S_IDLE) || w_swap);
  assign w_beat   = (r_state == S_LOAD) && valid_i;
  assign w_last   = w_beat && ({1'b0, r_cnt} == (r_len - 1'b1));
  // On a simultaneous swap+start the bank that was active becomes the new shadow.
  assign w_clear_bank = w_swap ? r_bank_sel : ~r_bank_sel;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_start) w_next = S_LOAD;
      S_LOAD: if (w_last)  w_next = S_FULL;
      S_FULL: if (swap_i)  w_next = w_start ? S_LOAD : S_IDLE;
      default:             w_next = S_IDLE;
    endcase
  end

  // Bank storage, bank select, load counter and latched length.
  // The shadow bank is zeroed when a load starts so that packages beyond len read as zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_bank[0]  <= '0;
      r_bank[1]  <= '0;
      r_bank_sel <= 1'b0;
      r_cnt      <= '0;
      r_len      <= '0;
    end else begin
      if (w_swap) begin
        r_bank_sel <= ~r_bank_sel;
      end
      if (w_start) begin
        r_len                <= len_i;
        r_cnt                <= '0;
        r_bank[w_clear_bank] <= '0;
      end else if (w_beat) begin
        r_bank[~r_bank_sel][r_cnt*DW +: DW] <= data_i;
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      end
    end
  end

  assign ready_o    = (r_state == S_LOAD);
  assign loaded_o   = (r_state == S_FULL);
  assign bank_sel_o = r_bank_sel;
  assign bias_o     = r_bank[r_bank_sel];

endmodule

// File: tb/tb_bias_reg_bank_pp.sv
// -----------------------------------------------------------------------------
// tb_bias_reg_bank_pp
//
// Directed testbench for bias_reg_bank_pp at default parameters
// (PACKAGE_LEN = 32 words of 16 bits, PACKAGE_NUM = 16 packages).
// A vector table covers single-cycle ignore/accept behaviour; hand-written
// sequences cover full loads, swap+start, and reset in the middle of a load.
// -----------------------------------------------------------------------------
module tb_bias_reg_bank_pp;

  localparam int FW = 16;
  localparam int DW = 512;
  localparam int RL = 512;
  localparam int PL = DW / FW;
  localparam int PN = RL / PL;
  localparam int AW = $clog2(PN);

  logic              clk_i;
  logic              rst_i;
  logic              start_i;
  logic [AW:0]       len_i;
  logic              valid_i;
  logic [DW-1:0]     data_i;
  logic              swap_i;
  logic              ready_o;
  logic              loaded_o;
  logic              bank_sel_o;
  logic [RL*FW-1:0]  bias_o;

  int nChecks = 0;
  int nErrors = 0;

  typedef struct {
    logic        start;
    logic [AW:0] len;
    logic        valid;
    logic        swap;
    logic [15:0] word;
    logic        eReady;
    logic        eLoaded;
    logic        eSel;
    logic [15:0] eP0;
    logic [15:0] eP15;
  } vec_t;

  vec_t        vecs [11];
  logic [15:0] expW [16];

  bias_reg_bank_pp #(.FW(FW), .DW(DW), .RL(RL)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .len_i      (len_i),
    .valid_i    (valid_i),
    .data_i     (data_i),
    .swap_i     (swap_i),
    .ready_o    (ready_o),
    .loaded_o   (loaded_o),
    .bank_sel_o (bank_sel_o),
    .bias_o     (bias_o)
  );

  // Free-running 10 ns clock
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Compare one value against its expectation and log any failure
  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare every package of bias_o against a replicated expected word
  task automatic checkBias(input string name, input logic [15:0] w [16]);
    for (int k = 0; k < PN; k++) begin
      checkOutput($sformatf("%s pkg%0d", name, k), bias_o[k*DW +: DW], {PL{w[k]}});
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then sample just after the rising edge
  task automatic applyStimulus(input logic st, input logic [AW:0] ln, input logic vl,
                               input logic sw, input logic [15:0] w);
    @(negedge clk_i);
    start_i = st;
    len_i   = ln;
    valid_i = vl;
    swap_i  = sw;
    data_i  = {PL{w}};
    @(posedge clk_i);
    #1;
  endtask

  // Control outputs in one call
  task automatic checkCtrl(input string name, input logic r, input logic l, input logic s);
    checkOutput({name, " ready"},  DW'(ready_o),    DW'(r));
    checkOutput({name, " loaded"}, DW'(loaded_o),   DW'(l));
    checkOutput({name, " sel"},    DW'(bank_sel_o), DW'(s));
  endtask

  // Main test sequence
  initial begin
    int c;
    rst_i   = 1'b1;
    start_i = 1'b0;
    len_i   = '0;
    valid_i = 1'b0;
    swap_i  = 1'b0;
    data_i  = '0;

    // Reset alone, before any clock edge
    #2;
    checkCtrl("reset", 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < PN; k++) expW[k] = 16'h0;
    checkBias("reset bias", expW);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Full 16-package load with a valid gap every third cycle
    applyStimulus(1'b1, 5'd16, 1'b0, 1'b0, 16'h0);
    checkCtrl("load16 start", 1'b1, 1'b0, 1'b0);
    c = 1;
    for (int k = 0; k < PN; k++) begin
      if (c % 3 == 2) begin
        applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 16'hFFFF);
        checkOutput($sformatf("load16 gap%0d ready", k), DW'(ready_o), DW'(1'b1));
        c++;
      end
      applyStimulus(1'b0, 5'd0, 1'b1, 1'b0, 16'(k + 1));
      c++;
      if (k < PN - 1) checkOutput($sformatf("load16 beat%0d ready", k), DW'(ready_o), DW'(1'b1));
    end
    checkCtrl("load16 full", 1'b0, 1'b1, 1'b0);
    checkBias("load16 bias still zero", expW);
    applyStimulus(1'b1, 5'd3, 1'b0, 1'b0, 16'h0);
    checkCtrl("start in FULL ignored", 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b1, 16'h0);
    checkCtrl("load16 swap", 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < PN; k++) expW[k] = 16'(k + 1);
    checkBias("load16 swapped", expW);

    // Short load of 3 packages: the remaining packages must read as zero
    applyStimulus(1'b1, 5'd3, 1'b0, 1'b0, 16'h0);
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 5'd0, 1'b1, 1'b0, 16'hAAAA);
    checkCtrl("load3 full", 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b1, 16'h0);
    checkCtrl("load3 swap", 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < PN; k++) expW[k] = (k < 3) ? 16'hAAAA : 16'h0;
    checkBias("load3 swapped", expW);

    // Single-cycle vectors: ignored commands, a len=2 load, stall and swap
    vecs[0]  = '{1'b0, 5'd0,  1'b0, 1'b1, 16'h0,    1'b0, 1'b0, 1'b0, 16'hAAAA, 16'h0};
    vecs[1]  = '{1'b1, 5'd0,  1'b0, 1'b0, 16'h0,    1'b0, 1'b0, 1'b0, 16'hAAAA, 16'h0};
    vecs[2]  = '{1'b1, 5'd17, 1'b0, 1'b0, 16'h0,    1'b0, 1'b0, 1'b0, 16'hAAAA, 16'h0};
    vecs[3]  = '{1'b0, 5'd0,  1'b1, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 16'hAAAA, 16'h0};
    vecs[4]  = '{1'b1, 5'd2,  1'b0, 1'b0, 16'h0,    1'b1, 1'b0, 1'b0, 16'hAAAA, 16'h0};
    vecs[5]  = '{1'b1, 5'd16, 1'b0, 1'b0, 16'h0,    1'b1, 1'b0, 1'b0, 16'hAAAA, 16'h0};
    vecs[6]  = '{1'b0, 5'd0,  1'b0, 1'b1, 16'h0,    1'b1, 1'b0, 1'b0, 16'hAAAA, 16'h0};
    vecs[7]  = '{1'b0, 5'd0,  1'b1, 1'b0, 16'h1234, 1'b1, 1'b0, 1'b0, 16'hAAAA, 16'h0};
    vecs[8]  = '{1'b0, 5'd0,  1'b0, 1'b0, 16'h9999, 1'b1, 1'b0, 1'b0, 16'hAAAA, 16'h0};
    vecs[9]  = '{1'b0, 5'd0,  1'b1, 1'b0, 16'h4321, 1'b0, 1'b1, 1'b0, 16'hAAAA, 16'h0};
    vecs[10] = '{1'b0, 5'd0,  1'b0, 1'b1, 16'h0,    1'b0, 1'b0, 1'b1, 16'h1234, 16'h0};
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].start, vecs[i].len, vecs[i].valid, vecs[i].swap, vecs[i].word);
      checkCtrl($sformatf("vec%0d", i), vecs[i].eReady, vecs[i].eLoaded, vecs[i].eSel);
      checkOutput($sformatf("vec%0d p0", i),  bias_o[0 +: DW],    {PL{vecs[i].eP0}});
      checkOutput($sformatf("vec%0d p15", i), bias_o[15*DW +: DW], {PL{vecs[i].eP15}});
    end
    checkOutput("vec p1", bias_o[DW +: DW], {PL{16'h4321}});

    // Fill the shadow, then swap and start together; active bank must hold steady while reloading
    applyStimulus(1'b1, 5'd16, 1'b0, 1'b0, 16'h0);
    for (int k = 0; k < PN; k++) applyStimulus(1'b0, 5'd0, 1'b1, 1'b0, 16'(16'h0100 + k));
    checkCtrl("pp fill full", 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 5'd16, 1'b0, 1'b1, 16'h0);
    checkCtrl("swap+start", 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < PN; k++) expW[k] = 16'(16'h0100 + k);
    checkBias("swap+start bias", expW);
    for (int k = 0; k < PN; k++) begin
      applyStimulus(1'b0, 5'd0, 1'b1, 1'b0, 16'(16'hB000 + k));
      checkOutput($sformatf("reload beat%0d p0", k),  bias_o[0 +: DW],     {PL{16'h0100}});
      checkOutput($sformatf("reload beat%0d p15", k), bias_o[15*DW +: DW], {PL{16'h010F}});
    end
    checkCtrl("reload full", 1'b0, 1'b1, 1'b0);
    checkBias("reload bias unchanged", expW);
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b1, 16'h0);
    checkCtrl("reload swap", 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < PN; k++) expW[k] = 16'(16'hB000 + k);
    checkBias("reload swapped", expW);

    // Reset in the middle of a load, then an immediate new load on the first edge
    applyStimulus(1'b1, 5'd16, 1'b0, 1'b0, 16'h0);
    for (int k = 0; k < 5; k++) applyStimulus(1'b0, 5'd0, 1'b1, 1'b0, 16'h7777);
    checkCtrl("partial load", 1'b1, 1'b0, 1'b1);
    #2;
    rst_i   = 1'b1;
    valid_i = 1'b0;
    #1;
    checkCtrl("mid-load reset", 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < PN; k++) expW[k] = 16'h0;
    checkBias("mid-load reset bias", expW);
    @(negedge clk_i);
    rst_i   = 1'b0;
    start_i = 1'b1;
    len_i   = 5'd2;
    @(posedge clk_i);
    #1;
    checkCtrl("post-reset start", 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'd0, 1'b1, 1'b0, 16'h0C0C);
    applyStimulus(1'b0, 5'd0, 1'b1, 1'b0, 16'h0D0D);
    checkCtrl("post-reset full", 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b1, 16'h0);
    checkCtrl("post-reset swap", 1'b0, 1'b0, 1'b1);
    expW[0] = 16'h0C0C;
    expW[1] = 16'h0D0D;
    checkBias("post-reset bias", expW);

    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 16'h0);
    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
